seq_mult32: RTL

//  Sequential 32x32 unsigned shift-add multiplier producing a 64-bit product.

---
 rtl/seq_mult32_pkg.sv | 15 +
 rtl/seq_mult32_hybrid.sv | 33 +++
 rtl/seq_mult32.sv | 109 ++++++++++
 3 files changed

// File: rtl/seq_mult32_pkg.sv
// Shared definitions for the sequential 32x32 shift-add multiplier:
// FSM state encodings and iteration/counter sizing.
package seq_mult32_pkg;

  localparam int MULT_W     = 32;
  localparam int MULT_CNT_W = 6;
  localparam int MULT_ITER  = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult32_hybrid.sv
// 32-bit hybrid adder: ripple lower half, carry-select upper half.
// Carry-out is exposed so the multiplier never loses the 33rd bit.
module seq_mult32_hybrid
  import seq_mult32_pkg::*;
(
  input  logic [MULT_W-1:0] a_i,
  input  logic [MULT_W-1:0] b_i,
  input  logic              cin_i,
  output logic [MULT_W-1:0] sum_o,
  output logic              cout_o
);

  localparam int HALF = MULT_W / 2;

  logic [HALF:0] lo_sum;
  logic [HALF:0] hi_sum0;
  logic [HALF:0] hi_sum1;

  // Lower half ripples; upper half is precomputed for both incoming carries
  always_comb begin
    lo_sum  = {1'b0, a_i[HALF-1:0]} + {1'b0, b_i[HALF-1:0]} + {{HALF{1'b0}}, cin_i};
    hi_sum0 = {1'b0, a_i[MULT_W-1:HALF]} + {1'b0, b_i[MULT_W-1:HALF]};
    hi_sum1 = {1'b0, a_i[MULT_W-1:HALF]} + {1'b0, b_i[MULT_W-1:HALF]} + {{HALF{1'b0}}, 1'b1};
    if (lo_sum[HALF]) begin
      sum_o  = {hi_sum1[HALF-1:0], lo_sum[HALF-1:0]};
      cout_o = hi_sum1[HALF];
    end else begin
      sum_o  = {hi_sum0[HALF-1:0], lo_sum[HALF-1:0]};
      cout_o = hi_sum0[HALF];
    end
  end

endmodule

// File: rtl/seq_mult32.sv
// Sequential 32x32 unsigned shift-add multiplier, 64-bit product.
// One operation in flight; 32 add/shift iterations, optional zero-operand
// fast path, valid/ready on both the operand and product sides.
module seq_mult32
  import seq_mult32_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_e                  state_q;
  logic [MULT_W-1:0]       mcand_q;
  logic [MULT_W-1:0]       acc_hi_q;
  logic [MULT_W-1:0]       acc_lo_q;
  logic [MULT_CNT_W-1:0]   cnt_q;
  logic [2*MULT_W-1:0]     product_q;

  logic [MULT_W-1:0]       addend;
  logic [MULT_W-1:0]       sum;
  logic                    carry;
  logic [MULT_W-1:0]       acc_hi_d;
  logic [MULT_W-1:0]       acc_lo_d;
  logic                    zero_op;

  // Partial product: add the multiplicand only when the current multiplier bit is set
  always_comb begin
    addend   = acc_lo_q[0] ? mcand_q : '0;
    // 65-bit right shift of {carry, sum, acc_lo}: carry lands in bit 63
    acc_hi_d = {carry, sum[MULT_W-1:1]};
    acc_lo_d = {sum[0], acc_lo_q[MULT_W-1:1]};
    zero_op  = ZERO_FAST && ((a == '0) || (b == '0));
  end

  seq_mult32_hybrid u_add (
    .a_i    (acc_hi_q),
    .b_i    (addend),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (carry)
  );

  // Control FSM, iteration counter and accumulator shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (clear) begin
      // Abort wins over every handshake; the last product is left untouched
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mcand_q  <= a;
            acc_lo_q <= b;
            acc_hi_q <= '0;
            cnt_q    <= '0;
            if (zero_op) begin
              product_q <= '0;
              state_q   <= S_DONE;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + MULT_CNT_W'(1);
          if (cnt_q == MULT_CNT_W'(MULT_ITER - 1)) begin
            product_q <= {acc_hi_d, acc_lo_d};
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from the state register
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    product   = product_q;
  end

endmodule
